// File: rtl/pipeline_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_pkg
// Shared types and constants for the pipeline hazard controller:
//   - md_state_e : HI/LO multiply/divide unit tracking states
//   - REG_ZERO   : architectural register $0, which is never a real dependency
//   - md_cnt_width(): width of the HI/LO latency down-counter, sized from the
//                     longer of the multiply and divide latencies
// -----------------------------------------------------------------------------
package pipeline_hazard_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    // The counter is loaded with (latency - 1), so $clog2 of the larger
    // latency is always wide enough. Latencies are at least 2, giving >= 1 bit.
    function automatic int md_cnt_width(input int mul_c, input int div_c);
        int m;
        m = (mul_c > div_c) ? mul_c : div_c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int MD_CNT_W_DEF = md_cnt_width(MUL_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/muldiv_busy_counter.sv
// -----------------------------------------------------------------------------
// muldiv_busy_counter
// Tracks the multi-cycle HI/LO multiply/divide unit. A start pulse loads a
// down-counter with (latency - 1); the unit reports busy until the cycle in
// which the counter reaches zero, after which it returns to idle.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   MD_IDLE | unit free, waiting for md_start
//   MD_MUL  | multiply in flight, counter = cycles remaining - 1
//   MD_DIV  | divide in flight, counter = cycles remaining - 1
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-low reset
//   md_start  in   start pulse (only honoured in MD_IDLE)
//   is_div    in   qualifies md_start: 1 = divide, 0 = multiply
//   md_busy   out  unit busy (state != MD_IDLE)
// -----------------------------------------------------------------------------
module muldiv_busy_counter
    import pipeline_hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic is_div,
    output logic md_busy
);

    localparam int CW = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    md_state_e     r_state;
    md_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (md_start) begin
                    w_state_nxt = is_div ? MD_DIV : MD_MUL;
                    w_cnt_nxt   = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_MUL, MD_DIV: begin
                // Counter == 0 marks the last busy cycle.
                if (r_cnt == '0) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign md_busy = (r_state != MD_IDLE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects
// load-use hazards that EX forwarding cannot cover, stalls on HI/LO accesses
// while the multiply/divide unit is busy, and flushes on taken branches.
//
// Build option:
//   HAZARD_PERF_CNT_EN  defined   -> saturating stall-cycle counter built
//                       undefined -> perf_stall_cnt tied to zero
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   id_rs_addr/rt_addr    source registers of the ID instruction
//   id_uses_rs/rt         ID instruction actually reads rs / rt
//   id_is_mul/div         ID instruction is mult(u) / div(u)
//   id_is_mfhilo          ID instruction is mfhi/mflo/mthi/mtlo
//   id_ex_MemRead         EX instruction is a load
//   id_ex_write_addr      EX instruction destination
//   ex_branch_taken       EX branch/jump resolved taken
//   pc_write              PC load enable
//   if_id_write           IF/ID enable
//   if_id_flush           IF/ID clear to nop
//   id_ex_bubble          ID/EX load nop
//   md_start              start pulse to HI/LO unit
//   md_busy               HI/LO unit busy
//   perf_stall_cnt        stall-cycle count
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mul,
    input  logic             id_is_div,
    input  logic             id_is_mfhilo,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_write_addr,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_load_use;
    logic w_md_hazard;
    logic w_stall;
    logic w_is_muldiv;

    assign w_rs_match  = id_uses_rs && (id_rs_addr == id_ex_write_addr);
    assign w_rt_match  = id_uses_rt && (id_rt_addr == id_ex_write_addr);
    // A load into $0 produces nothing to wait for.
    assign w_load_use  = id_ex_MemRead && (id_ex_write_addr != REG_ZERO)
                         && (w_rs_match || w_rt_match);
    assign w_is_muldiv = id_is_mul || id_is_div;
    assign w_md_hazard = md_busy && (id_is_mfhilo || w_is_muldiv);
    assign w_stall     = (w_load_use || w_md_hazard) && !ex_branch_taken;

    // A muldiv held by a load-use stall must not start early; the reset term
    // keeps a stray start from escaping while the unit is held cleared.
    assign md_start = reset && w_is_muldiv && !md_busy && !ex_branch_taken
                      && !w_load_use;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    muldiv_busy_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .is_div   (id_is_div),
        .md_busy  (md_busy)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_cnt <= '0;
        end else if (w_stall && (r_perf_cnt != {CNT_W{1'b1}})) begin
            r_perf_cnt <= r_perf_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_mul;
    logic        id_is_div;
    logic        id_is_mfhilo;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_write_addr;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        md_start;
    logic        md_busy;
    logic [15:0] perf_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_perf = 0;

    pipeline_hazard_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_is_mul        (id_is_mul),
        .id_is_div        (id_is_div),
        .id_is_mfhilo     (id_is_mfhilo),
        .id_ex_MemRead    (id_ex_MemRead),
        .id_ex_write_addr (id_ex_write_addr),
        .ex_branch_taken  (ex_branch_taken),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .md_start         (md_start),
        .md_busy          (md_busy),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    task automatic chk_ctrl(input string tag, input logic [3:0] exp);
        chk(tag, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble}), 32'(exp));
    endtask

    task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk(tag, 32'(perf_stall_cnt), 32'(exp_perf));
`else
        chk(tag, 32'(perf_stall_cnt), 32'd0);
`endif
    endtask

    // Advance one clock; the model counts a stall cycle if the cycle stalled.
    task automatic adv(input bit stalled);
        if (stalled) exp_perf++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_mul = 1'b1; id_is_div = 1'b0; id_is_mfhilo = 1'b0;
        id_ex_MemRead = 1'b0; id_ex_write_addr = 5'd0;
        ex_branch_taken = 1'b0;

        // Reset: cleared state, start gated even with a mult in ID.
        adv(0); adv(0); #1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_start", 32'(md_start), 32'd0);
        chk_ctrl("rst_ctrl", 4'b1100);
        chk_perf("rst_perf");
        id_is_mul = 1'b0;
        reset = 1'b1;
        adv(0);

        // lw $2 in EX, add $3,$2,$4 in ID: one stall cycle.
        id_ex_MemRead = 1'b1; id_ex_write_addr = 5'd2;
        id_rs_addr = 5'd2; id_rt_addr = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        #1;
        chk_ctrl("lu_rs_ctrl", 4'b0001);
        chk("lu_rs_start", 32'(md_start), 32'd0);
        adv(1);
        id_ex_MemRead = 1'b0; #1;
        chk_ctrl("lu_after_ctrl", 4'b1100);
        chk_perf("lu_perf1");

        // lw $0 with ID reading $0: no hazard.
        id_ex_MemRead = 1'b1; id_ex_write_addr = 5'd0;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; #1;
        chk_ctrl("lu_r0_ctrl", 4'b1100);
        adv(0);

        // rt matches but is not read: no hazard; then read: hazard.
        id_ex_write_addr = 5'd5; id_rs_addr = 5'd1; id_rt_addr = 5'd5;
        id_uses_rs = 1'b1; id_uses_rt = 1'b0; #1;
        chk_ctrl("lu_rt_unused", 4'b1100);
        id_uses_rt = 1'b1; #1;
        chk_ctrl("lu_rt_ctrl", 4'b0001);
        adv(1);
        id_ex_MemRead = 1'b0; #1;
        chk_perf("lu_perf2");

        // mult from idle: one start pulse, busy for 4 cycles.
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_mul = 1'b1; #1;
        chk("mul_start", 32'(md_start), 32'd1);
        chk_ctrl("mul_ctrl", 4'b1100);
        adv(0);
        id_is_mul = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mul_busy%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("mul_nostart%0d", i), 32'(md_start), 32'd0);
            adv(0);
        end
        chk("mul_done", 32'(md_busy), 32'd0);

        // Back-to-back mult: second one stalls through every busy cycle.
        id_is_mul = 1'b1; #1;
        chk("b2b_start0", 32'(md_start), 32'd1);
        adv(0);
        for (int i = 0; i < 4; i++) begin
            chk_ctrl($sformatf("b2b_stall%0d", i), 4'b0001);
            chk($sformatf("b2b_hold%0d", i), 32'(md_start), 32'd0);
            adv(1);
        end
        chk("b2b_start1", 32'(md_start), 32'd1);
        chk_ctrl("b2b_go", 4'b1100);
        chk_perf("b2b_perf");
        adv(0);
        id_is_mul = 1'b0;
        for (int i = 0; i < 4; i++) adv(0);
        chk("b2b_done", 32'(md_busy), 32'd0);

        // div then mfhi: stall for 32 cycles, free on the first idle cycle.
        id_is_div = 1'b1; #1;
        chk("div_start", 32'(md_start), 32'd1);
        adv(0);
        id_is_div = 1'b0; id_is_mfhilo = 1'b1; #1;
        for (int i = 0; i < 32; i++) begin
            if (i == 0 || i == 31) begin
                chk_ctrl($sformatf("mfhi_stall%0d", i), 4'b0001);
                chk($sformatf("div_busy%0d", i), 32'(md_busy), 32'd1);
            end
            adv(1);
        end
        chk("div_done", 32'(md_busy), 32'd0);
        chk_ctrl("mfhi_go", 4'b1100);
        chk("mfhi_nostart", 32'(md_start), 32'd0);
        chk_perf("div_perf");
        id_is_mfhilo = 1'b0;
        adv(0);

        // Load-use together with taken branch: flush wins, no stall counted.
        id_ex_MemRead = 1'b1; id_ex_write_addr = 5'd7;
        id_rs_addr = 5'd7; id_uses_rs = 1'b1; ex_branch_taken = 1'b1; #1;
        chk_ctrl("br_lu_ctrl", 4'b1111);
        adv(0);
        chk_perf("br_perf");
        id_ex_MemRead = 1'b0; id_uses_rs = 1'b0; id_is_mul = 1'b1; #1;
        chk("br_nostart", 32'(md_start), 32'd0);
        adv(0);
        chk("br_idle", 32'(md_busy), 32'd0);
        ex_branch_taken = 1'b0; id_is_mul = 1'b0;

        // mult whose operand is being loaded: held by the load-use stall.
        id_ex_MemRead = 1'b1; id_ex_write_addr = 5'd3;
        id_rs_addr = 5'd3; id_uses_rs = 1'b1; id_is_mul = 1'b1; #1;
        chk("lu_mul_nostart", 32'(md_start), 32'd0);
        chk_ctrl("lu_mul_ctrl", 4'b0001);
        adv(1);
        id_ex_MemRead = 1'b0; #1;
        chk("lu_mul_start", 32'(md_start), 32'd1);
        adv(0);
        id_is_mul = 1'b0; id_uses_rs = 1'b0;
        for (int i = 0; i < 4; i++) adv(0);
        chk("lu_mul_done", 32'(md_busy), 32'd0);
        chk_perf("lu_mul_perf");

        // Reset during div at count 20 abandons the operation.
        id_is_div = 1'b1; #1;
        chk("rdiv_start", 32'(md_start), 32'd1);
        adv(0);
        id_is_div = 1'b0;
        for (int i = 0; i < 11; i++) adv(0);
        chk("rdiv_busy", 32'(md_busy), 32'd1);
        reset = 1'b0;
        adv(0);
        exp_perf = 0;
        chk("rdiv_busy_clr", 32'(md_busy), 32'd0);
        chk_perf("rdiv_perf_clr");
        id_is_mul = 1'b1; #1;
        chk("rdiv_gate", 32'(md_start), 32'd0);
        reset = 1'b1; #1;
        chk("rmul_start", 32'(md_start), 32'd1);
        adv(0);
        id_is_mul = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rmul_busy%0d", i), 32'(md_busy), 32'd1);
            adv(0);
        end
        chk("rmul_done", 32'(md_busy), 32'd0);
        chk_perf("final_perf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use hazards that EX-stage forwarding cannot cover, tracks the multi-cycle HI/LO multiply/divide unit, and resolves taken-branch flushes. Drives the PC, IF/ID and ID/EX pipeline-register enables. Sits beside the ID stage and complements the EX forwarding control.

## Interface
- MUL_CYCLES, 4: multiply latency in cycles, ≥2
- DIV_CYCLES, 32: divide latency in cycles, ≥2
- CNT_W, 16: performance counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- id_rs_addr, id_rt_addr  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_is_mul, id_is_div  in  1 each  ID instruction is mult(u) / div(u)
- id_is_mfhilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- id_ex_MemRead  in  1  instruction in EX is a load
- id_ex_write_addr  in  5  destination of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clear to nop
- id_ex_bubble  out  1  ID/EX load nop
- md_start  out  1  start pulse to HI/LO unit
- md_busy  out  1  HI/LO unit busy
- perf_stall_cnt  out  CNT_W  stall-cycle count

## Operation
- load_use = id_ex_MemRead && id_ex_write_addr≠0 && ((id_uses_rs && match rs) || (id_uses_rt && match rt)).
- md_hazard = md_busy && (id_is_mfhilo || id_is_mul || id_is_div).
- stall = (load_use || md_hazard) && !ex_branch_taken.
- Priority 1, ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. Any stall or start is suppressed.
- Priority 2, stall: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- Otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0.
- md_start = (id_is_mul || id_is_div) && !md_busy && !ex_branch_taken && !load_use.
- HI/LO FSM states:
  - IDLE: on md_start, load the counter with MUL_CYCLES-1 or DIV_CYCLES-1 and go to MUL or DIV.
  - MUL / DIV: decrement the counter each cycle. When counter==0, return to IDLE.
- md_busy = (state≠IDLE).
- Back-to-back operation: a muldiv in ID during the last busy cycle (counter==0) still stalls. It starts on the following cycle, from IDLE.
- perf_stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Reset while low (sampled on the clock edge): state=IDLE, counter=0, perf_stall_cnt=0. Combinational outputs follow the cleared state.
  - In reset: md_busy=0, md_start=0.
  - With ex_branch_taken=0 and id_ex_MemRead=0 in reset: pc_write=1, if_id_write=1, flush=0, bubble=0.
- Reset during MUL/DIV abandons the operation with no completion indication.

## Timing
- All enable/flush/bubble outputs and md_start are combinational, same cycle as the inputs.
- State, counter and perf counter update on the rising clk edge.
- A load-use stall lasts exactly 1 cycle: the load advances and MemRead clears.
- Multiply: md_busy is high for exactly MUL_CYCLES cycles, starting the cycle after md_start.
- Divide: md_busy is high for exactly DIV_CYCLES cycles, starting the cycle after md_start.
- An mfhi issued while busy stalls until the first cycle with md_busy=0.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stall_cnt is implemented as above.
- Not defined: no counter register is built and perf_stall_cnt is tied to 0.

## Structure
- Package pipeline_hazard_pkg holds:
  - HI/LO state enum (IDLE, MUL, DIV)
  - register-zero constant (5'd0)
  - counter width derived from max(MUL_CYCLES, DIV_CYCLES)
- One sub-module, muldiv_busy_counter: FSM plus down-counter with md_start, is_div → md_busy.
- Hazard decode and priority logic stay in the top module.

## Test plan
- lw $2 in EX, add $3,$2,$4 in ID: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; perf_stall_cnt 0→1.
- lw $0 in EX, ID reads $0: no stall, all enables 1.
- mult in ID from IDLE (MUL_CYCLES=4): md_start pulses 1 cycle; md_busy is 1 for 4 cycles.
- mfhi follows div (DIV_CYCLES=32): stall until md_busy drops; no stall on the first cycle with md_busy=0.
- Load-use and ex_branch_taken in the same cycle: if_id_flush=1, id_ex_bubble=1, pc_write=1; perf counter unchanged.
- reset=0 on the edge during DIV with count 20: next cycle md_busy=0, perf_stall_cnt=0. A mult then starts normally.
